data_io_download: RTL
=====================

DATA_IO_DOWNLOAD -- requirements
Module: data_io_download

Interface
REQ-001 Parameter START_ADDR, default 25'h0000000, address of the first byte written by each download.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchroniser flops on each SPI input (legal 2..3).
REQ-003 clk_sys  input  1  single system clock; every register is clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 SPI_SCK  input  1  SPI clock from the ARM io controller, asynchronous to clk_sys.
REQ-006 SPI_SS2  input  1  active-low data-io chip select.
REQ-007 SPI_DI  input  1  SPI data from the controller, MSB first.
REQ-008 ioctl_download  output  1  high while a file transfer is open.
REQ-009 ioctl_index  output  8  file/menu index of the current or most recent download.
REQ-010 ioctl_wr  output  1  one-cycle write strobe; ioctl_addr and ioctl_dout are valid in that cycle.
REQ-011 ioctl_addr  output  25  byte address of the current write.
REQ-012 ioctl_dout  output  8  byte being written.

Function
REQ-013 Each of SPI_SCK, SPI_SS2 and SPI_DI SHALL pass through SYNC_STAGES flops; all decoding SHALL use the synchronised copies only.
REQ-014 A SCK rising edge SHALL be detected in the clk_sys cycle where the synchronised SCK is 1 and its previous value was 0; clk_sys SHALL be at least 4x SPI_SCK.
REQ-015 On each detected edge with synchronised SS2 low, SPI_DI SHALL be shifted into an 8-bit register MSB first, and a 3-bit bit counter SHALL increment, wrapping 7->0.
REQ-016 Synchronised SS2 high SHALL clear the bit counter and return the byte FSM to CMD; a partial byte SHALL be discarded.
REQ-017 Byte FSM states: CMD, PARAM, DATA. The first byte after SS2 falls is the command; CMD->PARAM for 0x53 (FILE_TX) or 0x55 (FILE_INDEX); CMD->DATA for 0x54 (FILE_TX_DAT); any other command SHALL go to an IGNORE state that holds until SS2 rises.
REQ-018 FILE_TX parameter 0xFF SHALL set ioctl_download and load the address counter with START_ADDR; parameter 0x00 SHALL clear ioctl_download; other values SHALL be ignored.
REQ-019 FILE_INDEX parameter SHALL load ioctl_index; writes to ioctl_index while ioctl_download=1 SHALL be ignored.
REQ-020 In DATA, each complete byte SHALL, while ioctl_download=1, assert ioctl_wr for exactly one cycle, the cycle after the edge that completed the byte, with ioctl_dout = the byte and ioctl_addr = the current counter. In DATA with ioctl_download=0, bytes SHALL be dropped with no strobe.
REQ-021 The address counter SHALL increment by 1 in the cycle after each ioctl_wr and wrap 25'h1FFFFFF->0 without flagging.
REQ-022 ioctl_addr and ioctl_dout SHALL hold their values between strobes.
REQ-023 Multiple FILE_TX_DAT transactions (SS2 toggling) inside one open download SHALL continue addressing contiguously.

Reset
REQ-024 Reset SHALL set ioctl_download=0, ioctl_wr=0, ioctl_index=8'h00, ioctl_addr=START_ADDR, ioctl_dout=8'h00, bit counter=0, FSM=CMD, and all synchroniser flops to SCK=0, SS2=1, DI=0.
REQ-025 Reset asserted mid-byte or mid-download SHALL abort without issuing any further ioctl_wr; a strobe pending in the reset cycle SHALL be suppressed.

Configuration
REQ-026 Macro DATA_IO_SIZE_EN: when defined, an extra output ioctl_size [24:0] SHALL hold the number of bytes written, cleared on FILE_TX 0xFF and reset, and frozen on FILE_TX 0x00 and while idle.
REQ-027 Without DATA_IO_SIZE_EN, ioctl_size and its counter SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-028 SCK = clk_sys/8; send 0x55,0x03 then 0x53,0xFF, then 0x54,0xA5,0x5A, then 0x53,0x00 -> ioctl_index=0x03; two strobes: (addr 0, 0xA5) and (addr 1, 0x5A); ioctl_download 1->0.
REQ-029 Drop SS2 after 5 bits of data byte 0x77 -> no strobe; the next full byte 0x12 is written at the unchanged address.
REQ-030 START_ADDR=25'h1FFFFFF, send 2 data bytes -> strobes at 25'h1FFFFFF then 25'h0000000.
REQ-031 0x54,0x11 with ioctl_download=0, and command 0x99 followed by 0xFF -> no strobe, ioctl_download stays 0.
REQ-032 Assert reset for 1 cycle during the 6th bit of the 3rd data byte -> outputs at reset values, no strobe; a new download restarts at START_ADDR.
REQ-033 With DATA_IO_SIZE_EN, download 300 bytes -> ioctl_size=300 after FILE_TX 0x00; the same test without the macro passes REQ-028 unchanged.

Source files
------------

// File: rtl/data_io_download_if.sv
// data_io_download_if: ioctl download bus; ioctl_size exists only with DATA_IO_SIZE_EN.
interface data_io_download_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
`ifdef DATA_IO_SIZE_EN
  logic [24:0] ioctl_size;
  modport master(output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_size);
  modport slave(input ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_size);
`else
  modport master(output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout);
  modport slave(input ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout);
`endif
endinterface

// File: rtl/data_io_download.sv
// data_io_download: SPI data-io receiver that turns FILE_TX/FILE_INDEX/FILE_TX_DAT into ioctl byte writes.
// Optional DATA_IO_SIZE_EN adds ioctl_size, the byte count of the current/last download.
module data_io_download #(
  parameter logic [24:0] START_ADDR  = 25'h0000000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic SPI_SCK,
  input  logic SPI_SS2,
  input  logic SPI_DI,
  data_io_download_if.master io
);
  typedef enum logic [1:0] {CMD, PARAM, DATA, IGNORE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sck_s, ss_s, di_s;
  logic        sck_q, wr, download;
  logic [2:0]  cnt;
  logic [6:0]  sr;
  logic [7:0]  cmd, rx, index, dout;
  logic [24:0] addr;
  logic        sck, ss, di, shift, byte_done, param_done, data_done, tx_open, tx_close, idx_ld;
  assign sck        = sck_s[SYNC_STAGES-1];
  assign ss         = ss_s[SYNC_STAGES-1];
  assign di         = di_s[SYNC_STAGES-1];
  assign shift      = sck & ~sck_q & ~ss;
  assign byte_done  = shift & (cnt == 3'd7);
  assign rx         = {sr, di};
  assign param_done = byte_done & (state == PARAM);
  assign data_done  = byte_done & (state == DATA) & download;
  assign tx_open    = param_done & (cmd == 8'h53) & (rx == 8'hFF);
  assign tx_close   = param_done & (cmd == 8'h53) & (rx == 8'h00);
  assign idx_ld     = param_done & (cmd == 8'h55) & ~download;
  always_ff @(posedge clk_sys)
    state <= reset ? CMD : state_n;
  always_comb begin
    state_n = state;
    state_n = ss ? CMD :
              !byte_done ? state :
              state == CMD ? ((rx == 8'h53 || rx == 8'h55) ? PARAM : rx == 8'h54 ? DATA : IGNORE) :
              state == PARAM ? IGNORE : state;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sck_s    <= '0;
      ss_s     <= '1;
      di_s     <= '0;
      sck_q    <= 1'b0;
      cnt      <= 3'd0;
      sr       <= 7'd0;
      cmd      <= 8'h00;
      download <= 1'b0;
      index    <= 8'h00;
      wr       <= 1'b0;
      dout     <= 8'h00;
      addr     <= START_ADDR;
    end else begin
      sck_s <= {sck_s[SYNC_STAGES-2:0], SPI_SCK};
      ss_s  <= {ss_s[SYNC_STAGES-2:0], SPI_SS2};
      di_s  <= {di_s[SYNC_STAGES-2:0], SPI_DI};
      sck_q <= sck;
      cnt   <= ss ? 3'd0 : shift ? cnt + 3'd1 : cnt;
      if (shift) sr <= rx[6:0];
      if (byte_done && state == CMD) cmd <= rx;
      download <= tx_open ? 1'b1 : tx_close ? 1'b0 : download;
      if (idx_ld) index <= rx;
      wr <= data_done;
      if (data_done) dout <= rx;
      addr <= tx_open ? START_ADDR : wr ? addr + 25'd1 : addr;
    end
  end
`ifdef DATA_IO_SIZE_EN
  logic [24:0] size;
  always_ff @(posedge clk_sys)
    size <= (reset || tx_open) ? 25'd0 : wr ? size + 25'd1 : size;
  assign io.ioctl_size = size;
`endif
  // a strobe already registered when reset arrives must not reach the bus
  assign io.ioctl_wr       = wr & ~reset;
  assign io.ioctl_download = download;
  assign io.ioctl_index    = index;
  assign io.ioctl_addr     = addr;
  assign io.ioctl_dout     = dout;
endmodule
